nios2_button_pio: RTL and testbench

Parametrised Avalon-MM input PIO for push-buttons and switches on the Nios II system bus. It replaces a bare sampled input port with several added stages: per-bit synchroniser, per-bit debounce filter, edge-capture register with write-1-to-clear, per-bit IRQ mask and a level interrupt to the CPU. Read timing is one cycle of registered readdata.

---
 rtl/nios2_button_pio_pkg.sv | 16 +
 rtl/nios2_button_debounce.sv | 66 ++++++
 rtl/nios2_button_pio.sv | 91 +++++++++
 tb/tb_nios2_button_pio.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_button_pio_pkg.sv
// nios2_button_pio_pkg
//   Shared constants for the push-button / switch input PIO:
//   Avalon word addresses of the four registers and the edge-type encodings
//   accepted by the EDGE_TYPE parameter.
package nios2_button_pio_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_RAW     = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/nios2_button_debounce.sv
// nios2_button_debounce
//   One input bit: SYNC_STAGES-flop synchroniser followed by a stability
//   filter. deb takes the synchronised value once it has differed from deb
//   for DEBOUNCE_CYCLES consecutive clocks; DEBOUNCE_CYCLES = 0 reduces the
//   filter to a single register.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset (all state to IDLE_LEVEL / 0)
//   raw      asynchronous input bit
//   sync_out last synchroniser stage
//   deb      debounced level
module nios2_button_debounce
   import nios2_button_pio_pkg::*;
#(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter logic IDLE_LEVEL      = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic sync_out,
   output logic deb
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
      else          sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) deb <= IDLE_LEVEL;
            else          deb <= sync_out;
         end
      end else begin : g_filter
         localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
         localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

         logic [CW-1:0] cnt;

         // cnt counts consecutive clocks of disagreement already seen; the
         // clock that finds cnt == LAST and still disagreeing is the
         // DEBOUNCE_CYCLES-th one, so deb moves on that edge.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt <= '0;
               deb <= IDLE_LEVEL;
            end else if (sync_out == deb) begin
               cnt <= '0;
            end else if (cnt == LAST) begin
               deb <= sync_out;
               cnt <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   endgenerate

endmodule

// File: rtl/nios2_button_pio.sv
// nios2_button_pio
//   Avalon-MM input PIO for buttons/switches: per-bit synchroniser and
//   debounce, edge capture with write-1-to-clear, per-bit IRQ mask and a
//   registered level interrupt. Registered read data, latency 1.
// Ports:
//   clk, reset_n   system clock, asynchronous active-low reset
//   address        word address: 0 DATA, 1 RAW, 2 IRQMASK, 3 EDGECAPTURE
//   chipselect     slave select (qualifies writes only)
//   write_n        active-low write strobe
//   writedata      write data
//   readdata       registered read data, unused bits 0
//   irq            |(edgecapture & irqmask), registered
//   in_port        raw asynchronous inputs
module nios2_button_pio
   import nios2_button_pio_pkg::*;
#(
   parameter int   WIDTH           = 4,
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter int   EDGE_TYPE       = 1,
   parameter logic IDLE_LEVEL      = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic             irq,
   input  logic [WIDTH-1:0] in_port
);

   logic [WIDTH-1:0] sync_out;
   logic [WIDTH-1:0] deb;
   logic [WIDTH-1:0] deb_d;
   logic [WIDTH-1:0] edges;
   logic [WIDTH-1:0] cap_clr;
   logic [WIDTH-1:0] edgecap;
   logic [WIDTH-1:0] irqmask;
   logic             wr;
   logic             unused_wdata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      nios2_button_debounce #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .IDLE_LEVEL      (IDLE_LEVEL)
      ) u_deb (
         .clk      (clk),
         .reset_n  (reset_n),
         .raw      (in_port[i]),
         .sync_out (sync_out[i]),
         .deb      (deb[i])
      );
   end

   assign wr           = chipselect & ~write_n;
   assign unused_wdata = ^writedata;

   always_comb begin
      edges   = deb ^ deb_d;
      if (EDGE_TYPE == EDGE_RISE)      edges = deb & ~deb_d;
      else if (EDGE_TYPE == EDGE_FALL) edges = ~deb & deb_d;
      cap_clr = '0;
      if (wr && address == ADDR_EDGECAP) cap_clr = writedata[WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         deb_d    <= {WIDTH{IDLE_LEVEL}};
         edgecap  <= '0;
         irqmask  <= '0;
         readdata <= '0;
         irq      <= 1'b0;
      end else begin
         deb_d   <= deb;
         // Set after clear: a new edge survives a simultaneous clear.
         edgecap <= (edgecap & ~cap_clr) | edges;
         if (wr && address == ADDR_IRQMASK) irqmask <= writedata[WIDTH-1:0];
         irq <= |(edgecap & irqmask);
         case (address)
            ADDR_DATA:    readdata <= 32'(deb);
            ADDR_RAW:     readdata <= 32'(sync_out);
            ADDR_IRQMASK: readdata <= 32'(irqmask);
            default:      readdata <= 32'(edgecap);
         endcase
      end
   end

endmodule

// File: tb/tb_nios2_button_pio.sv
module tb_nios2_button_pio;

   localparam int W  = 4;
   localparam int S  = 2;
   localparam int N  = 4;
   localparam int ET = 1;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [1:0]    address;
   logic          chipselect;
   logic          write_n;
   logic [31:0]   writedata;
   logic [31:0]   readdata;
   logic          irq;
   logic [W-1:0]  in_port;

   int n_tests = 0;
   int n_fail  = 0;

   nios2_button_pio #(
      .WIDTH           (W),
      .SYNC_STAGES     (S),
      .DEBOUNCE_CYCLES (N),
      .EDGE_TYPE       (ET),
      .IDLE_LEVEL      (1'b1)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq        (irq),
      .in_port    (in_port)
   );

   always #5 clk = ~clk;

   // Reference model: inputs reach the debouncer after S clocks; the
   // debounced level adopts a value once the last N synchronised samples
   // all carry it.
   typedef struct {
      logic        rd;
      logic [31:0] data;
      logic        irq;
   } exp_t;

   exp_t         sbq[$];
   logic [W-1:0] m_hist[$];
   logic [W-1:0] m_win[$];
   logic [W-1:0] m_deb, m_debd, m_cap, m_mask;

   task automatic model_reset();
      m_hist.delete();
      for (int k = 0; k < S; k++) m_hist.push_back('1);
      m_win.delete();
      m_deb  = '1;
      m_debd = '1;
      m_cap  = '0;
      m_mask = '0;
   endtask

   // Evaluated on the falling edge: uses the stable inputs to predict the
   // state and outputs produced by the following rising edge.
   always @(negedge clk) begin
      exp_t         e;
      logic [W-1:0] ev, clr, nd, smp;
      logic         all;
      if (!reset_n) begin
         model_reset();
         e.rd = 1'b1; e.data = '0; e.irq = 1'b0;
         sbq.push_back(e);
      end else begin
         e.rd  = chipselect & write_n;
         e.irq = |(m_cap & m_mask);
         case (address)
            2'd0:    e.data = 32'(m_deb);
            2'd1:    e.data = 32'(m_hist[0]);
            2'd2:    e.data = 32'(m_mask);
            default: e.data = 32'(m_cap);
         endcase
         sbq.push_back(e);

         case (ET)
            0:       ev = m_deb & ~m_debd;
            1:       ev = m_debd & ~m_deb;
            default: ev = m_deb ^ m_debd;
         endcase
         clr = '0;
         if (chipselect && !write_n && address == 2'd3) clr = writedata[W-1:0];
         m_cap = (m_cap & ~clr) | ev;
         if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];

         smp = m_hist[0];
         m_win.push_back(smp);
         if (m_win.size() > N) void'(m_win.pop_front());
         nd = m_deb;
         for (int i = 0; i < W; i++) begin
            if (m_win.size() == N) begin
               all = 1'b1;
               foreach (m_win[k]) if (m_win[k][i] == m_deb[i]) all = 1'b0;
               if (all) nd[i] = ~m_deb[i];
            end
         end
         m_debd = m_deb;
         m_deb  = nd;
         m_hist.push_back(in_port);
         void'(m_hist.pop_front());
      end
   end

   // Monitor: after every rising edge compare irq, and readdata when a read
   // was presented on that edge.
   always @(posedge clk) begin
      exp_t e;
      #2;
      if (sbq.size() != 0) begin
         e = sbq.pop_front();
         n_tests++;
         if (irq !== e.irq) begin
            n_fail++;
            $display("FAIL irq @%0t: got %b expected %b", $time, irq, e.irq);
         end
         if (e.rd) begin
            n_tests++;
            if (readdata !== e.data) begin
               n_fail++;
               $display("FAIL readdata @%0t: got %h expected %h", $time, readdata, e.data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [1:0] a);
      address = a; chipselect = 1'b1; write_n = 1'b1;
      tick();
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
      tick();
      write_n = 1'b1;
   endtask

   task automatic hold(input int n);
      for (int k = 0; k < n; k++) rd(2'($urandom_range(0, 3)));
   endtask

   task automatic pulse_reset();
      #2 reset_n = 1'b0;
      tick(); tick();
      #2 reset_n = 1'b1;
      tick();
   endtask

   initial begin
      bit found;
      reset_n = 1'b0; in_port = 4'hF; address = '0;
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;
      repeat (3) @(posedge clk);
      #3 reset_n = 1'b1;
      tick();

      // idle after reset: DATA=F, EDGECAP=0, no spurious edge
      rd(2'd0); rd(2'd3); hold(10); rd(2'd3);

      // press bit 2 and watch RAW, DATA, EDGECAP as it settles
      in_port = 4'hB;
      for (int k = 0; k < 10; k++) rd(2'(k % 2));
      rd(2'd3); hold(4);

      // 3-cycle glitch on bit 0 must be filtered
      in_port = 4'hA; hold(3);
      in_port = 4'hB; hold(10); rd(2'd0); rd(2'd3);

      // mask, clear, partial clear
      wr(2'd2, 32'h4); rd(2'd2); hold(2);
      wr(2'd3, 32'h4); rd(2'd3); hold(2);
      in_port = 4'hA; hold(12);
      in_port = 4'hE; hold(12);
      in_port = 4'hA; hold(12); rd(2'd3);
      wr(2'd3, 32'h1); rd(2'd3); hold(2);

      // clear of bit 1 on the very edge that captures bit 1
      in_port = 4'h8;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         if (m_deb[1] != m_debd[1]) begin
            wr(2'd3, 32'h2);
            found = 1'b1;
         end else begin
            rd(2'd3);
         end
      end
      n_tests++;
      if (!found) begin
         n_fail++;
         $display("FAIL edge_wait: got timeout expected bit1 edge within 40 cycles");
      end
      rd(2'd3); rd(2'd3);
      in_port = 4'hF; hold(12);
      wr(2'd3, 32'hF); hold(3);

      // reset in the middle of debouncing a held button
      in_port = 4'h7; hold(4);
      pulse_reset();
      rd(2'd0); rd(2'd3);
      hold(12); rd(2'd3);
      wr(2'd2, 32'hF); hold(3);

      // randomized traffic
      for (int it = 0; it < 400; it++) begin
         int r;
         if ($urandom_range(0, 5) == 0) in_port = W'($urandom);
         r = $urandom_range(0, 9);
         if (r == 0)      wr(2'd2, $urandom);
         else if (r == 1) wr(2'd3, $urandom);
         else if (r == 2) wr(2'($urandom_range(0, 1)), $urandom);
         else             rd(2'($urandom_range(0, 3)));
         if (it == 200) pulse_reset();
      end
      hold(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
